// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, command codes and helpers for the SPI target
package spi_pkg;

   localparam int         SPI_BYTE_W  = 8;
   localparam logic [7:0] SPI_IDLE_TX = 8'h00;

   // Command bytes exchanged with the diagnostics controller
   typedef enum logic [7:0] {
      CMD_PARITY_ERROR = 8'h22,
      CMD_RESUME       = 8'h55,
      CMD_READ_MEMORY  = 8'h66,
      CMD_READ_CONFIG  = 8'h77,
      CMD_READ_VRAM    = 8'h88,
      CMD_WRITE_MEMORY = 8'h99,
      CMD_HALT         = 8'hAA
   } spi_cmd_e;

   // Byte presented to the shift register at a load point: buffered byte or idle filler
   function automatic logic [SPI_BYTE_W-1:0] tx_next(input logic                  valid,
                                                     input logic [SPI_BYTE_W-1:0] buffered);
      return valid ? buffered : SPI_IDLE_TX;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-stage single-bit synchronizer with selectable reset value
module spi_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic fpga_clk,
   input  logic rst,
   input  logic rst_val,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages;

   // Shift the asynchronous input through the flop chain; oldest stage is the output
   always_ff @(posedge fpga_clk or posedge rst) begin
      if (rst) begin
         stages <= {SYNC_STAGES{rst_val}};
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode 0 byte-oriented SPI target bridged into the system clock
module spi_slave import spi_pkg::*; #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   output logic                  o_RX_DV,
   output logic [SPI_BYTE_W-1:0] o_RX_Byte,
   input  logic                  i_TX_DV,
   input  logic [SPI_BYTE_W-1:0] i_TX_Byte,
   input  logic                  i_SPI_Clk,
   output logic                  o_SPI_MISO,
   input  logic                  i_SPI_MOSI,
   input  logic                  i_SPI_CS_n
);

   logic                  sck_s, mosi_s, csn_s;
   logic                  sck_d, csn_d;
   logic                  sck_rise, sck_fall, frame_start, load_pt;
   logic [2:0]            bit_cnt;
   logic [SPI_BYTE_W-2:0] rx_sr;
   logic                  reload_pend;
   logic [SPI_BYTE_W-1:0] tx_buf;
   logic                  tx_valid;
   logic [SPI_BYTE_W-1:0] tx_sr;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .fpga_clk (i_Clk), .rst (i_Rst), .rst_val (1'b0), .d (i_SPI_Clk),  .q (sck_s)
   );
   spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .fpga_clk (i_Clk), .rst (i_Rst), .rst_val (1'b0), .d (i_SPI_MOSI), .q (mosi_s)
   );
   spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
      .fpga_clk (i_Clk), .rst (i_Rst), .rst_val (1'b1), .d (i_SPI_CS_n), .q (csn_s)
   );

   assign sck_rise    =  sck_s & ~sck_d;
   assign sck_fall    = ~sck_s &  sck_d;
   assign frame_start =  csn_d & ~csn_s;
   // Frame start and the falling edge after a completed byte both consume the TX buffer
   assign load_pt     = frame_start | (sck_fall & reload_pend);
   assign o_SPI_MISO  = tx_sr[SPI_BYTE_W-1];

   // Edge detection, RX shifting, TX buffering and TX shifting in one registered block
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sck_d       <= 1'b0;
         csn_d       <= 1'b1;
         o_RX_DV     <= 1'b0;
         o_RX_Byte   <= '0;
         bit_cnt     <= '0;
         rx_sr       <= '0;
         reload_pend <= 1'b0;
         tx_buf      <= '0;
         tx_valid    <= 1'b0;
         tx_sr       <= '0;
      end else begin
         sck_d   <= sck_s;
         csn_d   <= csn_s;
         o_RX_DV <= 1'b0;
         if (csn_s) begin
            // Idle: drop any partial byte and keep MISO primed with the pending byte
            bit_cnt     <= '0;
            rx_sr       <= '0;
            reload_pend <= 1'b0;
            if (i_TX_DV) begin
               tx_buf   <= i_TX_Byte;
               tx_valid <= 1'b1;
               tx_sr    <= i_TX_Byte;
            end else begin
               tx_sr <= tx_next(tx_valid, tx_buf);
            end
         end else begin
            if (load_pt) begin
               tx_sr       <= i_TX_DV ? i_TX_Byte : tx_next(tx_valid, tx_buf);
               tx_valid    <= 1'b0;
               reload_pend <= 1'b0;
            end else begin
               if (sck_fall) begin
                  tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
               end
               if (i_TX_DV) begin
                  tx_buf   <= i_TX_Byte;
                  tx_valid <= 1'b1;
               end
            end
            if (sck_rise) begin
               rx_sr   <= {rx_sr[SPI_BYTE_W-3:0], mosi_s};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  o_RX_Byte   <= {rx_sr, mosi_s};
                  o_RX_DV     <= 1'b1;
                  reload_pend <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       tx_dv;
   logic [7:0] tx_byte;
   logic       spi_sck;
   logic       spi_miso;
   logic       spi_mosi;
   logic       spi_csn;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         last_rise_cyc = 0;
   int         lat      = -1;
   int         rx_count = 0;
   logic [7:0] last_rx  = 8'h00;
   logic [7:0] rx_log[$];
   logic       prev_dv  = 1'b0;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .o_RX_DV    (rx_dv),
      .o_RX_Byte  (rx_byte),
      .i_TX_DV    (tx_dv),
      .i_TX_Byte  (tx_byte),
      .i_SPI_Clk  (spi_sck),
      .o_SPI_MISO (spi_miso),
      .i_SPI_MOSI (spi_mosi),
      .i_SPI_CS_n (spi_csn)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (rx_dv === 1'b1) begin
         check("rx_dv_single_cycle", {31'd0, prev_dv}, 32'd0);
         rx_count++;
         last_rx = rx_byte;
         rx_log.push_back(rx_byte);
         lat = cyc - last_rise_cyc;
      end
      prev_dv = rx_dv;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_tx(input logic [7:0] b);
      tx_dv   = 1'b1;
      tx_byte = b;
      wait_clks(1);
      tx_dv   = 1'b0;
   endtask

   // Mode 0 master: MOSI set while SCK low, MISO sampled at the rising edge
   task automatic spi_xfer(input logic [7:0] mosi_byte, input int nbits, input bit reply,
                           output logic [7:0] miso_byte);
      bit sent = 1'b0;
      miso_byte = 8'h00;
      for (int b = 0; b < nbits; b++) begin
         spi_mosi = mosi_byte[7-b];
         wait_clks(8);
         miso_byte = {miso_byte[6:0], spi_miso};
         spi_sck = 1'b1;
         if (b == 7) last_rise_cyc = cyc;
         for (int i = 0; i < 8; i++) begin
            wait_clks(1);
            if (tx_dv) begin
               tx_dv = 1'b0;
            end else if (reply && b == 7 && !sent && rx_dv) begin
               tx_dv   = 1'b1;
               tx_byte = mosi_byte + 8'h10;
               sent    = 1'b1;
            end
         end
         tx_dv   = 1'b0;
         spi_sck = 1'b0;
      end
      if (reply) check("reply_strobe_sent", {31'd0, sent}, 32'd1);
      wait_clks(8);
   endtask

   initial begin
      logic [7:0] got;
      int         snap;

      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got;
      int         snap;

      rst = 1'b1; spi_sck = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
      tx_dv = 1'b0; tx_byte = 8'h00;
      wait_clks(3);
      check("reset_rx_dv",   {31'd0, rx_dv},    32'd0);
      check("reset_rx_byte", {24'd0, rx_byte},  32'h00);
      check("reset_miso",    {31'd0, spi_miso}, 32'd0);
      rst = 1'b0;
      wait_clks(5);

      // Plain byte 0xAA with nothing queued for transmit
      spi_csn = 1'b0; wait_clks(8);
      spi_xfer(8'hAA, 8, 1'b0, got);
      spi_csn = 1'b1; wait_clks(10);
      check("t1_rx_count", rx_count, 1);
      check("t1_rx_byte",  {24'd0, last_rx}, 32'hAA);
      check("t1_latency_max", {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
      check("t1_miso",     {24'd0, got}, 32'h00);

      // Byte queued while deselected goes out first
      pulse_tx(8'h5C);
      wait_clks(5);
      spi_csn = 1'b0; wait_clks(8);
      spi_xfer(8'h66, 8, 1'b0, got);
      spi_csn = 1'b1; wait_clks(10);
      check("t2_miso",     {24'd0, got}, 32'h5C);
      check("t2_rx_count", rx_count, 2);
      check("t2_rx_byte",  {24'd0, last_rx}, 32'h66);

      // Back-to-back bytes with replies loaded after each o_RX_DV
      spi_csn = 1'b0; wait_clks(8);
      spi_xfer(8'h01, 8, 1'b1, got);
      check("t3_miso0", {24'd0, got}, 32'h00);
      spi_xfer(8'h02, 8, 1'b1, got);
      check("t3_miso1", {24'd0, got}, 32'h11);
      spi_xfer(8'h03, 8, 1'b1, got);
      check("t3_miso2", {24'd0, got}, 32'h12);
      spi_csn = 1'b1; wait_clks(10);
      check("t3_rx_count", rx_count, 5);
      check("t3_rx0", {24'd0, rx_log[2]}, 32'h01);
      check("t3_rx1", {24'd0, rx_log[3]}, 32'h02);
      check("t3_rx2", {24'd0, rx_log[4]}, 32'h03);

      // Partial byte aborted by CS_n, then a full byte
      spi_csn = 1'b0; wait_clks(8);
      spi_xfer(8'hFF, 5, 1'b0, got);
      spi_csn = 1'b1; wait_clks(10);
      check("t4_partial_no_dv", rx_count, 5);
      spi_csn = 1'b0; wait_clks(8);
      spi_xfer(8'h99, 8, 1'b0, got);
      spi_csn = 1'b1; wait_clks(10);
      check("t4_rx_count", rx_count, 6);
      check("t4_rx_byte",  {24'd0, last_rx}, 32'h99);
      check("t4_miso",     {24'd0, got}, 32'h00);

      // Latest TX strobe wins; unloaded next slot sends idle byte
      pulse_tx(8'h12);
      wait_clks(3);
      pulse_tx(8'h34);
      wait_clks(5);
      spi_csn = 1'b0; wait_clks(8);
      spi_xfer(8'hA5, 8, 1'b0, got);
      check("t5_miso_latest", {24'd0, got}, 32'h34);
      spi_xfer(8'h5A, 8, 1'b0, got);
      check("t5_miso_idle", {24'd0, got}, 32'h00);
      spi_csn = 1'b1; wait_clks(10);
      check("t5_rx_count", rx_count, 8);
      check("t5_rx_byte",  {24'd0, last_rx}, 32'h5A);

      // Reset in the middle of a byte
      pulse_tx(8'hC3);
      wait_clks(5);
      spi_csn = 1'b0; wait_clks(8);
      snap = rx_count;
      spi_xfer(8'hF0, 4, 1'b0, got);
      rst = 1'b1;
      wait_clks(2);
      check("t6_miso_in_reset",    {31'd0, spi_miso}, 32'd0);
      check("t6_rx_byte_in_reset", {24'd0, rx_byte},  32'h00);
      rst = 1'b0;
      spi_csn = 1'b1; wait_clks(10);
      check("t6_no_spurious_dv", rx_count, snap);
      spi_csn = 1'b0; wait_clks(8);
      spi_xfer(8'h77, 8, 1'b0, got);
      spi_csn = 1'b1; wait_clks(10);
      check("t6_rx_count", rx_count, snap + 1);
      check("t6_rx_byte",  {24'd0, last_rx}, 32'h77);
      check("t6_miso_after_reset", {24'd0, got}, 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
